im_responder: RTL and testbench

IM_RESPONDER -- requirements
Module: im_responder

---
 rtl/im_responder_pkg.sv | 31 +++
 rtl/im_line_store.sv | 65 ++++++
 rtl/im_responder.sv | 148 ++++++++++++++
 tb/tb_im_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/im_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : im_responder_pkg
//  Brief    : Shared fetch-stage definitions: refill state encoding, text
//             window defaults, address field positions and a range helper.
//  Revision : 1.0 - initial release
// ============================================================================
package im_responder_pkg;

   // Refill controller states, two-bit encoding.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REFILL = 2'd1
   } im_state_t;

   // Default text window (inclusive on both ends).
   localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
   localparam logic [31:0] IM_LIMIT_DEF = 32'h0000_6FFF;

   // Bit position of the word offset field; bits below it select a byte.
   localparam int IM_OFF_LSB = 2;

   // True when the address is inside the text window and word aligned.
   function automatic logic im_in_text(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
      return (addr >= lo) && (addr <= hi) && (addr[1:0] == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/im_line_store.sv
`default_nettype none
// ============================================================================
//  Module   : im_line_store
//  Brief    : Direct-mapped line storage: data words, tags and valid bits.
//             One write port (word write, tag+valid set on the last word),
//             a separate valid-clear, and one asynchronous read port.
//  Revision : 1.0 - initial release
// ============================================================================
module im_line_store
   import im_responder_pkg::*;
#(
   parameter int LINES = 4,
   parameter int WORDS = 4,
   parameter int IDX_W = 2,
   parameter int OFF_W = 2,
   parameter int TAG_W = 26
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_inv,
   input  logic [IDX_W-1:0] i_inv_idx,
   input  logic             i_wr,
   input  logic             i_wr_last,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic [OFF_W-1:0] i_wr_word,
   input  logic [31:0]      i_wr_data,
   input  logic [TAG_W-1:0] i_wr_tag,
   input  logic [IDX_W-1:0] i_rd_idx,
   input  logic [OFF_W-1:0] i_rd_word,
   output logic             o_rd_valid,
   output logic [TAG_W-1:0] o_rd_tag,
   output logic [31:0]      o_rd_data
);

   logic [31:0]      r_data  [LINES][WORDS];
   logic [TAG_W-1:0] r_tag   [LINES];
   logic [LINES-1:0] r_valid;

   // Valid bits: cleared by reset or when a refill starts, set by the last word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
      end else begin
         if (i_inv)
            r_valid[i_inv_idx] <= 1'b0;
         if (i_wr && i_wr_last)
            r_valid[i_wr_idx] <= 1'b1;
      end
   end

   // Data and tag arrays carry no reset; validity alone guards their use.
   always_ff @(posedge clk) begin
      if (i_wr) begin
         r_data[i_wr_idx][i_wr_word] <= i_wr_data;
         if (i_wr_last)
            r_tag[i_wr_idx] <= i_wr_tag;
      end
   end

   assign o_rd_valid = r_valid[i_rd_idx];
   assign o_rd_tag   = r_tag[i_rd_idx];
   assign o_rd_data  = r_data[i_rd_idx][i_rd_word];

endmodule
`default_nettype wire

// File: rtl/im_responder.sv
`default_nettype none
// ============================================================================
//  Module   : im_responder
//  Brief    : Direct-mapped instruction fetch responder. Hits return the word
//             in the same cycle; misses stall fetch while a whole line is
//             refilled from backing memory one word per acknowledged cycle.
//             Out-of-window or misaligned addresses return zero without
//             touching backing memory.
//  Revision : 1.0 - initial release
// ============================================================================
module im_responder
   import im_responder_pkg::*;
#(
   parameter int          LINES = 4,
   parameter int          WORDS = 4,
   parameter logic [31:0] BASE  = IM_BASE_DEF,
   parameter logic [31:0] LIMIT = IM_LIMIT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_im,
   output logic [31:0] instr,
   output logic        im_stall,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int OFF_W   = $clog2(WORDS);
   localparam int IDX_W   = $clog2(LINES);
   localparam int IDX_LSB = IM_OFF_LSB + OFF_W;
   localparam int TAG_LSB = IDX_LSB + IDX_W;
   localparam int TAG_W   = 32 - TAG_LSB;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

   // Refill controller state and the line it is filling.
   im_state_t        r_state;
   logic [OFF_W-1:0] r_k;
   logic [IDX_W-1:0] r_idx;
   logic [TAG_W-1:0] r_tag;
   logic             r_mem_rd;
   logic [31:0]      r_mem_addr;

   // Address fields of the current fetch.
   logic [TAG_W-1:0] w_tag;
   logic [IDX_W-1:0] w_idx;
   logic [OFF_W-1:0] w_off;

   // Lookup results and control decisions.
   logic             w_line_valid;
   logic [TAG_W-1:0] w_line_tag;
   logic [31:0]      w_line_word;
   logic             w_bypass;
   logic             w_idle;
   logic             w_hit;
   logic             w_miss;
   logic             w_xfer;
   logic             w_last;

   assign w_tag = pc_im[31:TAG_LSB];
   assign w_idx = pc_im[TAG_LSB-1:IDX_LSB];
   assign w_off = pc_im[IDX_LSB-1:IM_OFF_LSB];

   assign w_bypass = !im_in_text(pc_im, BASE, LIMIT);
   assign w_idle   = (r_state == ST_IDLE);
   assign w_hit    = w_idle && !w_bypass && w_line_valid && (w_line_tag == w_tag);
   assign w_miss   = w_idle && !w_bypass && !w_hit;

   // A word is transferred on every acknowledged refill cycle.
   assign w_xfer = (r_state == ST_REFILL) && mem_ack;
   assign w_last = w_xfer && (r_k == LAST_WORD);

   im_line_store #(
      .LINES (LINES),
      .WORDS (WORDS),
      .IDX_W (IDX_W),
      .OFF_W (OFF_W),
      .TAG_W (TAG_W)
   ) u_store (
      .clk        (clk),
      .reset      (reset),
      .i_inv      (w_miss),
      .i_inv_idx  (w_idx),
      .i_wr       (w_xfer),
      .i_wr_last  (w_last),
      .i_wr_idx   (r_idx),
      .i_wr_word  (r_k),
      .i_wr_data  (mem_rdata),
      .i_wr_tag   (r_tag),
      .i_rd_idx   (w_idx),
      .i_rd_word  (w_off),
      .o_rd_valid (w_line_valid),
      .o_rd_tag   (w_line_tag),
      .o_rd_data  (w_line_word)
   );

   // Refill FSM: latches the missing line, then walks its words; the
   // backing-memory request and address are registered FSM outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_k        <= '0;
         r_mem_rd   <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_miss) begin
                  r_state    <= ST_REFILL;
                  r_k        <= '0;
                  r_idx      <= w_idx;
                  r_tag      <= w_tag;
                  r_mem_rd   <= 1'b1;
                  r_mem_addr <= {pc_im[31:IDX_LSB], {IDX_LSB{1'b0}}};
               end
            end
            ST_REFILL: begin
               // Request and address hold until memory acknowledges.
               if (mem_ack) begin
                  if (r_k == LAST_WORD) begin
                     r_state    <= ST_IDLE;
                     r_k        <= '0;
                     r_mem_rd   <= 1'b0;
                     r_mem_addr <= '0;
                  end else begin
                     r_k        <= r_k + 1'b1;
                     r_mem_addr <= r_mem_addr + 32'd4;
                  end
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_k        <= '0;
               r_mem_rd   <= 1'b0;
               r_mem_addr <= '0;
            end
         endcase
      end
   end

   assign mem_rd   = r_mem_rd;
   assign mem_addr = r_mem_addr;
   assign im_stall = (r_state == ST_REFILL) || w_miss;
   assign instr    = w_hit ? w_line_word : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_im_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_im_responder
//  Brief    : Directed self-checking bench for im_responder. Backing memory
//             returns 32'h2400_0000 + address; acknowledge is driven per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_im_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc_im = 32'h0;
   logic [31:0] instr;
   logic        im_stall;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack = 1'b1;

   int total = 0;
   int bad   = 0;

   // Observations gathered by fetch()
   logic [31:0] xfer_addr [8];
   logic [31:0] hold_addr [8];
   int          n_stall, n_xfer, n_hold, n_rd;
   logic [31:0] got_instr;
   logic        timed_out;

   im_responder dut (
      .clk       (clk),
      .reset     (reset),
      .pc_im     (pc_im),
      .instr     (instr),
      .im_stall  (im_stall),
      .mem_rd    (mem_rd),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   assign mem_rdata = 32'h2400_0000 + mem_addr;

   // Present addr, run until stall drops (bounded); ack is withheld for
   // hold_cycles cycles while word number hold_word is being requested.
   task automatic fetch(input logic [31:0] addr, input int hold_word, input int hold_cycles);
      int hold_left;
      hold_left = hold_cycles;
      n_stall = 0; n_xfer = 0; n_hold = 0; n_rd = 0;
      got_instr = 32'hDEAD_BEEF; timed_out = 1'b1;
      @(negedge clk);
      pc_im = addr;
      for (int c = 0; c < 40; c++) begin
         mem_ack = !(mem_rd && (n_xfer == hold_word) && (hold_left > 0));
         #1;
         if (mem_rd) n_rd++;
         if (!im_stall) begin
            got_instr = instr;
            timed_out = 1'b0;
            break;
         end
         n_stall++;
         if (mem_rd) begin
            if (mem_ack) begin
               if (n_xfer < 8) xfer_addr[n_xfer] = mem_addr;
               n_xfer++;
            end else begin
               if (n_hold < 8) hold_addr[n_hold] = mem_addr;
               n_hold++;
               hold_left--;
            end
         end
         @(negedge clk);
      end
      mem_ack = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; pc_im = 32'h3000; mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
      total++; if (im_stall !== 1'b1) begin bad++; $display("FAIL reset_miss_3000: im_stall got %b want 1", im_stall); end
      total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 00000000", instr); end
      @(negedge clk);
      reset = 1'b0; pc_im = 32'h0;
      #1;
      total++; if (im_stall !== 1'b0) begin bad++; $display("FAIL reset_release_stall: got %b want 0", im_stall); end
   endtask

   task automatic test_first_miss();
      fetch(32'h3000, -1, 0);
      total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL miss3000_timeout: got %b want 0", timed_out); end
      total++; if (n_stall != 5) begin bad++; $display("FAIL miss3000_stall: got %0d want 5", n_stall); end
      total++; if (n_xfer != 4) begin bad++; $display("FAIL miss3000_xfers: got %0d want 4", n_xfer); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (xfer_addr[i] !== 32'h3000 + 32'(4 * i)) begin
            bad++; $display("FAIL miss3000_addr%0d: got %h want %h", i, xfer_addr[i], 32'h3000 + 32'(4 * i));
         end
      end
      total++; if (got_instr !== 32'h2400_3000) begin bad++; $display("FAIL miss3000_instr: got %h want 24003000", got_instr); end
   endtask

   task automatic test_hit();
      fetch(32'h300C, -1, 0);
      total++; if (n_stall != 0) begin bad++; $display("FAIL hit300c_stall: got %0d want 0", n_stall); end
      total++; if (n_rd != 0) begin bad++; $display("FAIL hit300c_mem_rd: got %0d cycles want 0", n_rd); end
      total++; if (got_instr !== 32'h2400_300C) begin bad++; $display("FAIL hit300c_instr: got %h want 2400300c", got_instr); end
      fetch(32'h3004, -1, 0);
      total++; if (got_instr !== 32'h2400_3004 || n_stall != 0) begin bad++; $display("FAIL hit3004: instr %h stall %0d want 24003004 0", got_instr, n_stall); end
   endtask

   task automatic test_evict();
      fetch(32'h3040, -1, 0);
      total++; if (n_stall != 5) begin bad++; $display("FAIL evict3040_stall: got %0d want 5", n_stall); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (xfer_addr[i] !== 32'h3040 + 32'(4 * i)) begin
            bad++; $display("FAIL evict3040_addr%0d: got %h want %h", i, xfer_addr[i], 32'h3040 + 32'(4 * i));
         end
      end
      total++; if (got_instr !== 32'h2400_3040) begin bad++; $display("FAIL evict3040_instr: got %h want 24003040", got_instr); end
      fetch(32'h3000, -1, 0);
      total++; if (n_stall != 5) begin bad++; $display("FAIL evict_remiss3000_stall: got %0d want 5", n_stall); end
      total++; if (got_instr !== 32'h2400_3000) begin bad++; $display("FAIL evict_remiss3000_instr: got %h want 24003000", got_instr); end
      fetch(32'h3008, -1, 0);
      total++; if (n_stall != 0 || got_instr !== 32'h2400_3008) begin bad++; $display("FAIL evict_hit3008: stall %0d instr %h want 0 24003008", n_stall, got_instr); end
   endtask

   task automatic test_ack_hold();
      fetch(32'h3010, 1, 3);
      total++; if (n_stall != 8) begin bad++; $display("FAIL hold_stall: got %0d want 8", n_stall); end
      total++; if (n_hold != 3) begin bad++; $display("FAIL hold_cycles: got %0d want 3", n_hold); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (hold_addr[i] !== 32'h3014) begin bad++; $display("FAIL hold_addr%0d: got %h want 00003014", i, hold_addr[i]); end
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (xfer_addr[i] !== 32'h3010 + 32'(4 * i)) begin
            bad++; $display("FAIL hold_xfer_addr%0d: got %h want %h", i, xfer_addr[i], 32'h3010 + 32'(4 * i));
         end
      end
      total++; if (got_instr !== 32'h2400_3010) begin bad++; $display("FAIL hold_instr: got %h want 24003010", got_instr); end
      fetch(32'h3014, -1, 0);
      total++; if (n_stall != 0 || got_instr !== 32'h2400_3014) begin bad++; $display("FAIL hold_word1_data: stall %0d instr %h want 0 24003014", n_stall, got_instr); end
   endtask

   task automatic test_bypass();
      logic [31:0] addrs [4];
      addrs[0] = 32'h0000_1000; addrs[1] = 32'h0000_3002;
      addrs[2] = 32'h0000_2FFC; addrs[3] = 32'h0000_7000;
      for (int i = 0; i < 4; i++) begin
         fetch(addrs[i], -1, 0);
         total++;
         if (n_stall != 0 || n_rd != 0 || got_instr !== 32'h0) begin
            bad++; $display("FAIL bypass_%h: stall %0d rd %0d instr %h want 0 0 00000000", addrs[i], n_stall, n_rd, got_instr);
         end
      end
   endtask

   task automatic test_limit();
      fetch(32'h6FFC, -1, 0);
      total++; if (n_stall != 5) begin bad++; $display("FAIL limit6ffc_stall: got %0d want 5", n_stall); end
      total++; if (xfer_addr[0] !== 32'h6FF0) begin bad++; $display("FAIL limit6ffc_base: got %h want 00006ff0", xfer_addr[0]); end
      total++; if (got_instr !== 32'h2400_6FFC) begin bad++; $display("FAIL limit6ffc_instr: got %h want 24006ffc", got_instr); end
   endtask

   task automatic test_reset_mid_refill();
      @(negedge clk);
      pc_im = 32'h3020; mem_ack = 1'b1;
      // Miss cycle, then words 0..2; the fourth negedge lands on word 3.
      repeat (4) @(negedge clk);
      #1;
      total++; if (mem_rd !== 1'b1 || mem_addr !== 32'h302C) begin bad++; $display("FAIL abort_pre: rd %b addr %h want 1 0000302c", mem_rd, mem_addr); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; pc_im = 32'h0;
      #1;
      total++; if (mem_rd !== 1'b0) begin bad++; $display("FAIL abort_mem_rd: got %b want 0", mem_rd); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL abort_mem_addr: got %h want 00000000", mem_addr); end
      fetch(32'h3020, -1, 0);
      total++; if (n_stall != 5 || n_xfer != 4) begin bad++; $display("FAIL abort_refill: stall %0d xfers %0d want 5 4", n_stall, n_xfer); end
      total++; if (xfer_addr[0] !== 32'h3020 || xfer_addr[3] !== 32'h302C) begin bad++; $display("FAIL abort_refill_addr: first %h last %h want 00003020 0000302c", xfer_addr[0], xfer_addr[3]); end
      total++; if (got_instr !== 32'h2400_3020) begin bad++; $display("FAIL abort_refill_instr: got %h want 24003020", got_instr); end
      fetch(32'h3000, -1, 0);
      total++; if (n_stall != 5) begin bad++; $display("FAIL abort_reset_cleared_3000: stall %0d want 5", n_stall); end
   endtask

   initial begin
      test_reset();
      test_first_miss();
      test_hit();
      test_evict();
      test_ack_hold();
      test_bypass();
      test_limit();
      test_reset_mid_refill();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
